// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback always wins, and aux results drain from an ordered queue.
// Pipeline writes kill stale queued entries. The pending flags report queued or in-flight writes to decode.
module rf_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        aux_valid,
  input  logic [4:0]  aux_addr,
  input  logic [31:0] aux_data,
  output logic        aux_ready,
  input  logic [4:0]  query_addr_1,
  input  logic [4:0]  query_addr_2,
  output logic        pending_1,
  output logic        pending_2,
  output logic        we,
  output logic [4:0]  write_address,
  output logic [31:0] data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [4:0]       addr_reg [DEPTH];
  logic [31:0]      entry_data_reg [DEPTH];
  logic [DEPTH-1:0] live_reg;
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  logic        we_reg;
  logic [4:0]  waddr_reg;
  logic [31:0] wdata_reg;

  logic prim_wr;
  logic push;
  logic enq;
  logic pop;
  logic head_live;

  assign prim_wr   = wb_we && (wb_addr != 5'd0);
  // The full check uses the registered count only, so a full queue refuses even while it pops.
  assign aux_ready = (count_reg < DEPTH_CNT);
  assign push      = aux_valid && aux_ready;
  assign enq       = push && (aux_addr != 5'd0);
  assign pop       = !prim_wr && (count_reg != '0);
  assign head_live = live_reg[head_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      live_reg  <= '0;
    end else begin
      if (enq) tail_reg <= tail_reg + PTR_W'(1);
      if (pop) head_reg <= head_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(enq) - CNT_W'(pop);
      for (int i = 0; i < DEPTH; i++) begin
        if (enq && (tail_reg == PTR_W'(i))) begin
          // A same-cycle aux entry counts as older than the primary write, so it is enqueued dead.
          live_reg[i] <= !(prim_wr && (aux_addr == wb_addr));
        end else if ((pop && (head_reg == PTR_W'(i))) ||
                     (prim_wr && (addr_reg[i] == wb_addr))) begin
          live_reg[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (enq && (tail_reg == PTR_W'(i))) begin
        addr_reg[i]       <= aux_addr;
        entry_data_reg[i] <= aux_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_reg    <= 1'b0;
      waddr_reg <= 5'd0;
      wdata_reg <= 32'd0;
    end else if (prim_wr) begin
      we_reg    <= 1'b1;
      waddr_reg <= wb_addr;
      wdata_reg <= wb_data;
    end else if (pop && head_live) begin
      we_reg    <= 1'b1;
      waddr_reg <= addr_reg[head_reg];
      wdata_reg <= entry_data_reg[head_reg];
    end else begin
      we_reg    <= 1'b0;
    end
  end

  logic [DEPTH-1:0] hit_1;
  logic [DEPTH-1:0] hit_2;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign hit_1[gi] = live_reg[gi] && (addr_reg[gi] == query_addr_1);
      assign hit_2[gi] = live_reg[gi] && (addr_reg[gi] == query_addr_2);
    end
  endgenerate

  assign pending_1 = (query_addr_1 != 5'd0) &&
                     ((|hit_1) || (we_reg && (waddr_reg == query_addr_1)));
  assign pending_2 = (query_addr_2 != 5'd0) &&
                     ((|hit_2) || (we_reg && (waddr_reg == query_addr_2)));

  assign we            = we_reg;
  assign write_address = waddr_reg;
  assign data          = wdata_reg;
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-side initiator for the 32x32 register file. It merges the pipeline writeback stream with a secondary stream of late results, such as multi-cycle mult/div or load-miss returns, into the RF's single write port. Aux results are buffered in a small ordered queue. The block kills queued results that a newer pipeline write makes stale, and reports pending-write hazards to decode. It sits between the WB stage / aux units and the RF write inputs (`we`, `write_address`, `data`).

## Interface
- `DEPTH`, 4: aux queue entries; power of two, 2..16.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low.
- `wb_we` input 1: pipeline writeback request; always accepted, never stalled.
- `wb_addr` input 5: pipeline destination register.
- `wb_data` input 32: pipeline result.
- `aux_valid` input 1: aux result offered.
- `aux_addr` input 5: aux destination register.
- `aux_data` input 32: aux result.
- `aux_ready` output 1: aux queue can accept this cycle.
- `query_addr_1`, `query_addr_2` input 5 each: decode source registers.
- `pending_1`, `pending_2` output 1 each: a queued or in-flight write targets the queried register.
- `we` output 1: registered RF write enable.
- `write_address` output 5: registered RF write address.
- `data` output 32: registered RF write data.

## Operation
- The aux queue is circular with `head`, `tail` and `count` (width clog2(DEPTH)+1). Each entry holds addr[4:0], data[31:0] and a live bit.
- `aux_ready` = (`count` < `DEPTH`), combinational from registered state only. It does not depend on a same-cycle pop, so a full queue never accepts, even while popping.
- **Push:** `aux_valid && aux_ready`.
  - `aux_addr` == 0: accepted and discarded, nothing enqueued.
  - Otherwise: enqueued at `tail` with live=1.
- **Primary:** `wb_we && wb_addr != 0` → output register loads `we`=1, `write_address`=`wb_addr`, `data`=`wb_data`. `wb_we` with `wb_addr`==0 is treated as idle.
- **Kill:** a primary write to address A clears live on every queued entry with addr A. This includes an aux entry pushed in the same cycle with A, which is treated as older and enqueued dead.
- **Pop:** happens only in a cycle with no primary write and `count` > 0.
  - Head live → output loads `we`=1 with head addr/data.
  - Head dead → output loads `we`=0.
  - In both cases `head` advances and `count` decrements.
- **Idle:** no primary write and empty queue → `we`=0; `write_address` and `data` hold their previous values.
- Simultaneous push and pop → `count` unchanged.
- `pending_n` = (any live entry with addr == `query_addr_n`) OR (`we` && `write_address` == `query_addr_n`). Query address 0 always gives 0. Purely combinational.
- Pointers wrap modulo `DEPTH`.

## Timing
- Inputs are sampled at rising edge k. Outputs update at edge k and are written into the RF at the following falling edge.
- Latency:
  - Primary: exactly 1 cycle.
  - Aux: at least 1 cycle after acceptance, plus one cycle per earlier queued entry, plus one cycle per primary write.
- Aux data may be starved indefinitely by continuous primary writes; decode must use `pending` to stall dependents.
- Reset asserted (any time, including mid-drain):
  - `we`=0, `write_address`=0, `data`=0.
  - `head`=`tail`=`count`=0, all live bits cleared, so `aux_ready`=1 and `pending_1`/`pending_2`=0.
  - Queued data is lost; upstream aux units must also be reset.
- On the first rising edge after deassertion, normal sampling resumes.

## Test plan
- **Primary only:** `wb_we`=1, `wb_addr`=5, `wb_data`=0xDEADBEEF at edge 1 → `we`=1, `write_address`=5, `data`=0xDEADBEEF after edge 1; with `wb_addr`=0 → `we`=0.
- **Arbitration:**
  - Push aux (7, 0x11) and (8, 0x22) while primary writes 3, 4 on the same two edges → output order 3, 4, 7, 8.
  - `pending` for query 7 stays 1 until the edge after the 7 write.
- **Kill:**
  - Queue aux (9, 0xAA); next cycle primary writes (9, 0xBB) → RF receives only 0xBB, one dead pop cycle with `we`=0 follows, and `pending_1`(9) drops to 0 after the primary write leaves the output register.
  - Same-cycle aux and primary on 9 → only the primary is written.
- **Full queue:**
  - Push 4 entries with the primary busy → `aux_ready`=0.
  - Assert `aux_valid` while full and popping → not accepted.
  - Next cycle `aux_ready`=1 and the entry is accepted.
  - Wrap: push/pop 10 entries, data order preserved.
- **$0 handling:** aux to address 0 → accepted, no write, `count` unchanged; query 0 → `pending`=0.
- **Reset mid-drain:** 3 entries queued, `reset` low between edges → outputs 0 immediately, `aux_ready`=1, no writes emitted after release.
